// File: rtl/pwm_duty_fader.sv
`timescale 1ns/1ps
// pwm_duty_fader
//   Generates a slowly breathing duty word for a downstream PWM generator.
//   The duty ramps from lo up to hi in STEP increments (one step per PWM
//   period), dwells HOLD periods at hi, ramps back down to lo, dwells HOLD
//   periods at lo and repeats. lo/hi are captured from duty_min/duty_max
//   only when leaving IDLE, so the limits can be changed freely while running.
//
// Parameters
//   R    duty resolution in bits; one PWM period is 2^R ticks
//   N    clk cycles per tick (prescaler), N >= 1
//   STEP duty change per PWM period, 1 <= STEP < 2^R
//   HOLD PWM periods spent at each extreme, HOLD >= 1
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset
//   en         run request; low returns the block to IDLE
//   duty_min   lower ramp limit (sampled on leaving IDLE)
//   duty_max   upper ramp limit (sampled on leaving IDLE)
//   duty       registered duty word
//   period_end one-cycle pulse on the last clk of each PWM period
//   state      current FSM state code (IDLE=0 UP=1 HOLD_H=2 DOWN=3 HOLD_L=4)
module pwm_duty_fader #(
  parameter int R    = 6,
  parameter int N    = 1,
  parameter int STEP = 1,
  parameter int HOLD = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [R-1:0] duty_min,
  input  logic [R-1:0] duty_max,
  output logic [R-1:0] duty,
  output logic         period_end,
  output logic [2:0]   state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(N - 1);
  localparam logic [R-1:0]  CNT_LAST   = '1;
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD - 1);
  localparam logic [R:0]    STEP_W     = (R + 1)'(STEP);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UP     = 3'd1,
    S_HOLD_H = 3'd2,
    S_DOWN   = 3'd3,
    S_HOLD_L = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [R-1:0]  duty_reg, duty_next;
  logic [R-1:0]  lo_reg, lo_next;
  logic [R-1:0]  hi_reg, hi_next;
  logic [R-1:0]  cnt_reg, cnt_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [HW-1:0] hold_reg, hold_next;
  logic          pe_reg, pe_next;

  logic          tick_wrap;
  logic          at_end;
  logic [R:0]    up_sum;
  logic [R:0]    lo_plus;

  // Ramp limit tests are done one bit wider so duty+STEP / lo+STEP can
  // never wrap around and make the ramp overshoot.
  assign tick_wrap = (presc_reg == PRESC_LAST);
  assign at_end    = tick_wrap && (cnt_reg == CNT_LAST);
  assign up_sum    = {1'b0, duty_reg} + STEP_W;
  assign lo_plus   = {1'b0, lo_reg} + STEP_W;

  always_comb begin
    state_next = state_reg;
    duty_next  = duty_reg;
    lo_next    = lo_reg;
    hi_next    = hi_reg;
    cnt_next   = cnt_reg;
    presc_next = presc_reg;
    hold_next  = hold_reg;

    // Free-running period timebase; IDLE and the en=0 path below zero it.
    if (tick_wrap) begin
      presc_next = '0;
      cnt_next   = cnt_reg + 1'b1;
    end else begin
      presc_next = presc_reg + 1'b1;
    end

    case (state_reg)
      S_IDLE: begin
        presc_next = '0;
        cnt_next   = '0;
        hold_next  = '0;
        duty_next  = '0;
        if (en) begin
          lo_next    = duty_min;
          hi_next    = (duty_max > duty_min) ? duty_max : duty_min;
          duty_next  = duty_min;
          state_next = S_UP;
        end
      end
      S_UP: begin
        if (at_end) begin
          if (up_sum >= {1'b0, hi_reg}) begin
            duty_next  = hi_reg;
            hold_next  = '0;
            state_next = S_HOLD_H;
          end else begin
            duty_next = up_sum[R-1:0];
          end
        end
      end
      S_HOLD_H: begin
        if (at_end) begin
          if (hold_reg == HOLD_LAST) begin
            hold_next  = '0;
            state_next = S_DOWN;
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end
      end
      S_DOWN: begin
        if (at_end) begin
          if ({1'b0, duty_reg} <= lo_plus) begin
            duty_next  = lo_reg;
            hold_next  = '0;
            state_next = S_HOLD_L;
          end else begin
            duty_next = duty_reg - STEP_W[R-1:0];
          end
        end
      end
      S_HOLD_L: begin
        if (at_end) begin
          if (hold_reg == HOLD_LAST) begin
            hold_next  = '0;
            state_next = S_UP;
          end else begin
            hold_next = hold_reg + 1'b1;
          end
        end
      end
      default: begin
        // Unused codes recover to IDLE on the next edge.
        state_next = S_IDLE;
        duty_next  = '0;
        presc_next = '0;
        cnt_next   = '0;
        hold_next  = '0;
      end
    endcase

    // Dropping en overrides everything, including a coincident period end.
    if (!en) begin
      state_next = S_IDLE;
      duty_next  = '0;
      presc_next = '0;
      cnt_next   = '0;
      hold_next  = '0;
    end

    // period_end is registered: it is high for the clk in which the
    // timebase sits on its final tick.
    pe_next = (state_next != S_IDLE) && (presc_next == PRESC_LAST) &&
              (cnt_next == CNT_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      duty_reg  <= '0;
      lo_reg    <= '0;
      hi_reg    <= '0;
      cnt_reg   <= '0;
      presc_reg <= '0;
      hold_reg  <= '0;
      pe_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      duty_reg  <= duty_next;
      lo_reg    <= lo_next;
      hi_reg    <= hi_next;
      cnt_reg   <= cnt_next;
      presc_reg <= presc_next;
      hold_reg  <= hold_next;
      pe_reg    <= pe_next;
    end
  end

  assign duty       = duty_reg;
  assign period_end = pe_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_pwm_duty_fader.sv
`timescale 1ns/1ps
// Bench for pwm_duty_fader. Three instances share clk/reset:
//   [0] STEP=1 N=1, [1] STEP=4 N=1, [2] STEP=1 N=3, all R=6 HOLD=2.
module tb_pwm_duty_fader;

  localparam int R    = 6;
  localparam int HOLD = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en_a   [3];
  logic [R-1:0] min_a  [3];
  logic [R-1:0] max_a  [3];
  logic [R-1:0] duty_a [3];
  logic         pe_a   [3];
  logic [2:0]   state_a[3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_fader #(.R(R), .N(1), .STEP(1), .HOLD(HOLD)) dut (
    .clk(clk), .reset(reset), .en(en_a[0]), .duty_min(min_a[0]), .duty_max(max_a[0]),
    .duty(duty_a[0]), .period_end(pe_a[0]), .state(state_a[0]));

  pwm_duty_fader #(.R(R), .N(1), .STEP(4), .HOLD(HOLD)) dut_s4 (
    .clk(clk), .reset(reset), .en(en_a[1]), .duty_min(min_a[1]), .duty_max(max_a[1]),
    .duty(duty_a[1]), .period_end(pe_a[1]), .state(state_a[1]));

  pwm_duty_fader #(.R(R), .N(3), .STEP(1), .HOLD(HOLD)) dut_n3 (
    .clk(clk), .reset(reset), .en(en_a[2]), .duty_min(min_a[2]), .duty_max(max_a[2]),
    .duty(duty_a[2]), .period_end(pe_a[2]), .state(state_a[2]));

  function automatic int step_of(input int sel);
    return (sel == 1) ? 4 : 1;
  endfunction

  function automatic int pre_of(input int sel);
    return (sel == 2) ? 3 : 1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout, expected period_end", name);
  endtask

  // Reference model: list of (duty, state) seen after each successive
  // period_end for one full breathing cycle starting in UP at lo.
  typedef struct {
    int duty;
    int st;
  } exp_t;
  exp_t exp_q[$];

  task automatic push_exp(input int d, input int s);
    exp_t e;
    e.duty = d;
    e.st   = s;
    exp_q.push_back(e);
  endtask

  task automatic build_model(input int lo, input int hi, input int step);
    exp_q.delete();
    for (int k = 1; lo + k * step < hi; k++) push_exp(lo + k * step, 1);
    push_exp(hi, 2);
    for (int k = 1; k < HOLD; k++) push_exp(hi, 2);
    push_exp(hi, 3);
    for (int k = 1; hi - k * step > lo; k++) push_exp(hi - k * step, 3);
    push_exp(lo, 4);
    for (int k = 1; k < HOLD; k++) push_exp(lo, 4);
    push_exp(lo, 1);
  endtask

  // Stop, load limits, start: returns #1 after the edge that leaves IDLE.
  task automatic start(input int sel, input int mn, input int mx);
    @(posedge clk); #1;
    en_a[sel] = 1'b0;
    @(posedge clk); #1;
    min_a[sel] = R'(mn);
    max_a[sel] = R'(mx);
    en_a[sel]  = 1'b1;
    @(posedge clk); #1;
  endtask

  // Waits for k period_end pulses, returns #1 after the edge that ends the last one.
  task automatic wait_pe(input int sel, input int k);
    int seen;
    int cyc;
    int budget;
    seen = 0;
    cyc = 0;
    budget = k * 64 * pre_of(sel) + 8;
    while (seen < k && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (pe_a[sel]) seen++;
    end
    if (seen < k) timeout_fail($sformatf("wait_pe[%0d]", sel));
    else begin
      @(posedge clk); #1;
    end
  endtask

  task automatic measure(input int sel, input int npulses);
    int last;
    int cyc;
    int seen;
    int bad;
    int budget;
    logic prev_pe;
    logic [R-1:0] prev_duty;
    last = -1;
    cyc = 0;
    seen = 0;
    bad = 0;
    budget = (npulses + 1) * 64 * pre_of(sel) + 8;
    prev_pe = 1'b0;
    prev_duty = duty_a[sel];
    while (seen < npulses && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (duty_a[sel] != prev_duty && !prev_pe) bad++;
      prev_duty = duty_a[sel];
      prev_pe = pe_a[sel];
      if (pe_a[sel]) begin
        if (last >= 0) check($sformatf("pe_spacing[%0d]", sel), cyc - last, 64 * pre_of(sel));
        last = cyc;
        seen++;
      end
    end
    if (seen < npulses) timeout_fail($sformatf("measure[%0d]", sel));
    check($sformatf("duty_mid_period[%0d]", sel), bad, 0);
  endtask

  typedef struct {
    bit restart;
    int dmin;
    int dmax;
    int wait_n;
    int exp_duty;
    int exp_state;
  } vec_t;

  vec_t tbl[12];

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int cnt;
    int lo;
    int hi;
    int sel;
    int budget;
    int idx;

    tbl[0]  = '{1, 10, 13, 0, 10, 1};
    tbl[1]  = '{0, 0, 0, 1, 11, 1};
    tbl[2]  = '{0, 0, 0, 2, 13, 2};
    tbl[3]  = '{0, 0, 0, 2, 13, 3};
    tbl[4]  = '{0, 0, 0, 3, 10, 4};
    tbl[5]  = '{0, 0, 0, 2, 10, 1};
    tbl[6]  = '{1, 13, 10, 0, 13, 1};
    tbl[7]  = '{0, 0, 0, 1, 13, 2};
    tbl[8]  = '{0, 0, 0, 2, 13, 3};
    tbl[9]  = '{0, 0, 0, 1, 13, 4};
    tbl[10] = '{1, 20, 20, 0, 20, 1};
    tbl[11] = '{0, 0, 0, 3, 20, 3};

    for (int i = 0; i < 3; i++) begin
      en_a[i]  = 1'b0;
      min_a[i] = '0;
      max_a[i] = '0;
    end

    // Asynchronous reset: outputs clear before any clk edge.
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_duty[%0d]", i), int'(duty_a[i]), 0);
      check($sformatf("reset_state[%0d]", i), int'(state_a[i]), 0);
      check($sformatf("reset_pe[%0d]", i), int'(pe_a[i]), 0);
    end
    #19 reset = 1'b0;

    // IDLE with en=0: nothing moves for 1000 cycles.
    cnt = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (pe_a[i]) cnt++;
    end
    check("idle_no_pe", cnt, 0);
    check("idle_state", int'(state_a[0]), 0);
    check("idle_duty", int'(duty_a[0]), 0);

    // Table-driven ramp checkpoints on instance 0.
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].restart) start(0, tbl[i].dmin, tbl[i].dmax);
      else wait_pe(0, tbl[i].wait_n);
      check($sformatf("tbl%0d_duty", i), int'(duty_a[0]), tbl[i].exp_duty);
      check($sformatf("tbl%0d_state", i), int'(state_a[0]), tbl[i].exp_state);
    end

    // Period timing and mid-period stability, N=1 and N=3.
    start(0, 10, 13);
    measure(0, 4);
    start(2, 5, 9);
    measure(2, 4);
    @(posedge clk); #1;
    en_a[2] = 1'b0;

    // STEP=4 full sweep: saturates at 63 going up and 0 going down.
    start(1, 0, 63);
    build_model(0, 63, 4);
    check("s4_start_duty", int'(duty_a[1]), 0);
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_pe(1, 1);
      check($sformatf("s4_pe%0d_duty", i + 1), int'(duty_a[1]), exp_q[i].duty);
      check($sformatf("s4_pe%0d_state", i + 1), int'(state_a[1]), exp_q[i].st);
    end

    // en dropped exactly on a period_end in UP: no increment applied.
    start(0, 10, 40);
    budget = 0;
    while (!pe_a[0] && budget < 80) begin
      @(negedge clk);
      budget++;
    end
    if (!pe_a[0]) timeout_fail("en_drop_wait");
    check("en_drop_pre_state", int'(state_a[0]), 1);
    en_a[0] = 1'b0;
    @(posedge clk); #1;
    check("en_drop_state", int'(state_a[0]), 0);
    check("en_drop_duty", int'(duty_a[0]), 0);
    check("en_drop_pe", int'(pe_a[0]), 0);

    // Degenerate ramp, then asynchronous reset mid-DOWN.
    start(0, 20, 20);
    build_model(20, 20, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      wait_pe(0, 1);
      check($sformatf("flat_pe%0d_duty", i + 1), int'(duty_a[0]), exp_q[i].duty);
      check($sformatf("flat_pe%0d_state", i + 1), int'(state_a[0]), exp_q[i].st);
    end
    budget = 0;
    while (state_a[0] != 3'd3 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    check("flat_reach_down", int'(state_a[0]), 3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_duty", int'(duty_a[0]), 0);
    check("async_rst_state", int'(state_a[0]), 0);
    #1 reset = 1'b0;

    // Randomized limits, with the limit inputs scrambled while running.
    for (int t = 0; t < 6; t++) begin
      sel = t % 2;
      lo = int'($urandom_range(0, 63));
      hi = int'($urandom_range(0, 63));
      start(sel, lo, hi);
      if (hi < lo) hi = lo;
      build_model(lo, hi, step_of(sel));
      $display("random trial %0d: inst %0d lo=%0d hi=%0d", t, sel, lo, hi);
      check($sformatf("rnd%0d_start_duty", t), int'(duty_a[sel]), lo);
      check($sformatf("rnd%0d_start_state", t), int'(state_a[sel]), 1);
      for (int i = 0; i < 40; i++) begin
        min_a[sel] = R'($urandom_range(0, 63));
        max_a[sel] = R'($urandom_range(0, 63));
        wait_pe(sel, 1);
        idx = i % exp_q.size();
        check($sformatf("rnd%0d_pe%0d_duty", t, i + 1), int'(duty_a[sel]), exp_q[idx].duty);
        check($sformatf("rnd%0d_pe%0d_state", t, i + 1), int'(state_a[sel]), exp_q[idx].st);
      end
      @(posedge clk); #1;
      en_a[sel] = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_duty_fader.md
PWM_DUTY_FADER -- requirements
Module: pwm_duty_fader

Interface
REQ-001 SHALL have parameter R, default 6, meaning duty resolution in bits (PWM period = 2^R ticks).
REQ-002 SHALL have parameter N, default 1, meaning clk cycles per tick (prescaler), N>=1.
REQ-003 SHALL have parameter STEP, default 1, meaning duty increment/decrement per PWM period, 1<=STEP<2^R.
REQ-004 SHALL have parameter HOLD, default 4, meaning PWM periods spent at each extreme, HOLD>=1.
REQ-005 SHALL provide ports: clk  in  1  system clock, rising edge.
REQ-006 SHALL provide ports: reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL provide ports: en  in  1  run request; low forces IDLE.
REQ-008 SHALL provide ports: duty_min  in  R  lower ramp limit, sampled only on leaving IDLE.
REQ-009 SHALL provide ports: duty_max  in  R  upper ramp limit, sampled only on leaving IDLE.
REQ-010 SHALL provide ports: duty  out  R  registered duty word for the downstream PWM generator.
REQ-011 SHALL provide ports: period_end  out  1  one-cycle pulse on the last clk of each PWM period.
REQ-012 SHALL provide ports: state  out  3  current FSM state code.

Function
REQ-013 SHALL implement states IDLE=0, UP=1, HOLD_H=2, DOWN=3, HOLD_L=4; codes 5-7 SHALL go to IDLE on the next edge.
REQ-014 SHALL run a prescaler 0..N-1 and a period counter 0..2^R-1 advancing once per prescaler wrap, only outside IDLE.
REQ-015 SHALL assert period_end for exactly one clk when prescaler=N-1 and period counter=2^R-1; period = 2^R*N clk cycles.
REQ-016 SHALL change duty only on a period_end edge or on an IDLE exit/entry, never mid-period.
REQ-017 IDLE with en=1 at an edge: latch lo=duty_min and hi=max(duty_min,duty_max); duty<=lo; counters<=0; go UP.
REQ-018 UP at period_end: if duty+STEP>=hi (computed in R+1 bits), duty<=hi, hold count<=0, go HOLD_H; else duty<=duty+STEP.
REQ-019 HOLD_H at period_end: increment hold count; at the HOLD-th period_end clear it and go DOWN; duty unchanged.
REQ-020 DOWN at period_end: if duty<=lo+STEP (R+1 bits), duty<=lo, hold count<=0, go HOLD_L; else duty<=duty-STEP.
REQ-021 HOLD_L at period_end: same as HOLD_H, exiting to UP after HOLD period_ends.
REQ-022 duty SHALL never wrap: always lo<=duty<=hi outside IDLE.
REQ-023 en=0 in any non-IDLE state: next edge go IDLE, duty<=0, counters and hold count <=0, period_end<=0; en=0 wins over a coincident period_end.
REQ-024 IDLE with en=0: all outputs held at reset values.
REQ-025 duty_min/duty_max changes outside IDLE SHALL have no effect.
REQ-026 lo=hi: ramp degenerates; duty SHALL stay at lo through all states while cycling normally.

Reset
REQ-027 reset=1 SHALL immediately, without a clk edge, force state=IDLE, duty=0, period_end=0, and all counters, hold count, lo and hi to 0.
REQ-028 After reset release, the first en=1 edge SHALL behave per REQ-017.

Verification (R=6, N=1, STEP=1, HOLD=2 unless stated)
REQ-029 Reset pulse at time 2 ns, en=0 -> duty=0, state=0, period_end=0; no period_end for 1000 cycles.
REQ-030 en=1, min=10, max=13 -> duty=10 on the next edge; period_end every 64 cycles; duty 11,12,13 after period_ends 1-3; state=2 after period_end 3; state=3 after period_end 5; duty 12,11,10 after period_ends 6-8; state=4; back to state=1 after period_end 10.
REQ-031 STEP=4, min=0, max=63 -> duty 0,4,...,60, then 63 (no wrap to 0); state=2; on the way down ...,7,3, then 0; state=4.
REQ-032 N=3 -> period_end spacing exactly 192 cycles; duty changes only on those edges.
REQ-033 en dropped on the same edge as a period_end in UP -> state=0, duty=0 next cycle; no increment applied.
REQ-034 min=max=20 -> duty=20 in every state; reset asserted mid-DOWN between clk edges -> duty=0, state=0 at once.
